// File: rtl/cache_arbiter.sv
// Merges the I-cache and D-cache line-granular memory ports onto one physical
// memory port, serving one transaction at a time with round-robin arbitration.
module cache_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t                state, state_n;
  grant_t                last_grant, last_grant_n;
  logic                  req_read, req_read_n;
  logic                  req_write, req_write_n;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_n;
  logic [LINE_WIDTH-1:0] req_wdata, req_wdata_n;
  logic                  d_req;

  assign d_req = d_pmem_read | d_pmem_write;

  // Memory side sees only latched request state; read data is broadcast.
  assign mem_read     = req_read;
  assign mem_write    = req_write;
  assign mem_address  = req_addr;
  assign mem_wdata    = req_wdata;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      req_read   <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      req_read   <= req_read_n;
      req_write  <= req_write_n;
      req_addr   <= req_addr_n;
      req_wdata  <= req_wdata_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    req_read_n   = req_read;
    req_write_n  = req_write;
    req_addr_n   = req_addr;
    req_wdata_n  = req_wdata;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    case (state)
      IDLE: begin
        // On contention the client that was not served last wins.
        if (i_pmem_read && (!d_req || last_grant == GRANT_D)) begin
          state_n      = SERVE_I;
          last_grant_n = GRANT_I;
          req_read_n   = 1'b1;
          req_write_n  = 1'b0;
          req_addr_n   = i_pmem_address;
        end else if (d_req) begin
          state_n      = SERVE_D;
          last_grant_n = GRANT_D;
          req_read_n   = ~d_pmem_write;
          req_write_n  = d_pmem_write;
          req_addr_n   = d_pmem_address;
          req_wdata_n  = d_pmem_wdata;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          state_n     = RECOVER;
          req_read_n  = 1'b0;
          req_write_n = 1'b0;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          state_n     = RECOVER;
          req_read_n  = 1'b0;
          req_write_n = 1'b0;
        end
      end
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata;

  logic auto_mem, auto_resp, man_resp;
  assign mem_resp = auto_mem ? auto_resp : man_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
  bit [1:0]      m_owner = 2'd0;
  bit            m_cool  = 1'b0;
  bit [1:0]      m_last  = 2'd2;
  bit            m_wr    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;

  int mem_cnt = 0;
  int rd_txns = 0;
  bit prev_rd = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_compare();
    bit busy;
    busy = (m_owner != 2'd0);
    chk("mem_read",  1'(mem_read),  1'(busy && !m_wr));
    chk("mem_write", 1'(mem_write), 1'(busy && m_wr));
    chk("i_resp",    1'(i_pmem_resp), 1'(m_owner == 2'd1 && mem_resp));
    chk("d_resp",    1'(d_pmem_resp), 1'(m_owner == 2'd2 && mem_resp));
    chk("i_rdata",   i_pmem_rdata, mem_rdata);
    chk("d_rdata",   d_pmem_rdata, mem_rdata);
    if (busy) chk("mem_address", LW'(mem_address), LW'(m_addr));
    if (busy && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic model_step();
    bit d_any;
    d_any = d_pmem_read | d_pmem_write;
    if (rst) begin
      m_owner = 2'd0; m_cool = 1'b0; m_last = 2'd2; m_wr = 1'b0;
    end else if (m_owner != 2'd0) begin
      if (mem_resp) begin m_owner = 2'd0; m_cool = 1'b1; end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else begin
      if (i_pmem_read && (!d_any || m_last == 2'd2)) begin
        m_owner = 2'd1; m_wr = 1'b0; m_addr = i_pmem_address;
      end else if (d_any) begin
        m_owner = 2'd2; m_wr = d_pmem_write; m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
      end
      if (m_owner != 2'd0) m_last = m_owner;
    end
  endtask

  // Checks the current cycle mid-period, after inputs have settled.
  task automatic check_cycle();
    @(negedge clk);
    if (chk_en) model_compare();
  endtask

  // Advances the model and memory responder into the next cycle.
  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
    if (mem_read || mem_write) begin
      if (mem_cnt == 3) begin auto_resp = 1'b1; mem_cnt = 0; end
      else begin auto_resp = 1'b0; mem_cnt++; end
    end else begin
      auto_resp = 1'b0; mem_cnt = 0;
    end
    if (mem_read && !prev_rd) rd_txns++;
    prev_rd = mem_read;
  endtask

  task automatic tick();
    check_cycle();
    advance();
  endtask

  // Waits for the selected client's resp; n = cycles after the first strobe cycle.
  task automatic run_until_resp(input bit is_d, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      check_cycle();
      if (is_d ? d_pmem_resp : i_pmem_resp) begin
        found = 1'b1;
        n = k;
      end else begin
        advance();
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=no_resp required=resp_within_40");
    end
  endtask

  logic [LW-1:0] pat_a5, pat_w, pat_w2;
  int n, base;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w  = {4{64'h0123_4567_89AB_CDEF}};
    pat_w2 = {4{64'hFEDC_BA98_7654_3210}};
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; auto_mem = 1'b1; auto_resp = 1'b0; man_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check_cycle();
    chk("rst_mem_read", 1'(mem_read), 1'b0);
    chk("rst_mem_write", 1'(mem_write), 1'b0);
    chk("rst_i_resp", 1'(i_pmem_resp), 1'b0);
    chk("rst_d_resp", 1'(d_pmem_resp), 1'b0);
    advance();

    // I-only read, memory answers three cycles after the strobe
    mem_rdata = pat_a5;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    tick();
    check_cycle();
    chk("t1_mem_read", 1'(mem_read), 1'b1);
    chk("t1_addr", LW'(mem_address), LW'(32'h0000_1000));
    advance();
    run_until_resp(1'b0, n);
    chk("t1_latency", LW'(n), LW'(3));
    chk("t1_i_resp", 1'(i_pmem_resp), 1'b1);
    chk("t1_i_rdata", i_pmem_rdata, pat_a5);
    chk("t1_d_resp", 1'(d_pmem_resp), 1'b0);
    advance();
    i_pmem_read = 1'b0;
    check_cycle();
    chk("t1_read_drop", 1'(mem_read), 1'b0);
    advance();
    tick();

    // D-only write-back
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = pat_w;
    tick();
    check_cycle();
    chk("t2_mem_write", 1'(mem_write), 1'b1);
    chk("t2_mem_read", 1'(mem_read), 1'b0);
    chk("t2_addr", LW'(mem_address), LW'(32'h0000_2040));
    chk("t2_wdata", mem_wdata, pat_w);
    advance();
    run_until_resp(1'b1, n);
    chk("t2_latency", LW'(n), LW'(3));
    chk("t2_i_resp", 1'(i_pmem_resp), 1'b0);
    advance();
    d_pmem_write = 1'b0;
    tick();
    tick();

    // Simultaneous requests after reset alternate I, D, I
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_5000;
    tick();
    check_cycle();
    chk("t3_first_i", LW'(mem_address), LW'(32'h0000_4000));
    advance();
    run_until_resp(1'b0, n);
    advance();
    i_pmem_read = 1'b0;
    tick();
    tick();
    check_cycle();
    chk("t3_then_d", LW'(mem_address), LW'(32'h0000_5000));
    chk("t3_d_read", 1'(mem_read), 1'b1);
    advance();
    run_until_resp(1'b1, n);
    advance();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4100;
    tick();
    tick();
    check_cycle();
    chk("t3_alt_i", LW'(mem_address), LW'(32'h0000_4100));
    advance();
    run_until_resp(1'b0, n);
    advance();
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
    tick();

    // Illegal D read+write is served as a write
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_3000; d_pmem_wdata = pat_w2;
    tick();
    check_cycle();
    chk("t4_mem_write", 1'(mem_write), 1'b1);
    chk("t4_mem_read", 1'(mem_read), 1'b0);
    advance();
    run_until_resp(1'b1, n);
    advance();
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    tick();
    tick();

    // Reset in the middle of a D transaction, then a late memory response
    auto_mem = 1'b0;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_6000; d_pmem_wdata = pat_w;
    tick();
    check_cycle();
    chk("t5_mem_write", 1'(mem_write), 1'b1);
    advance();
    tick();
    rst = 1'b1; d_pmem_write = 1'b0;
    tick();
    rst = 1'b0; man_resp = 1'b1;
    check_cycle();
    chk("t5_write_clr", 1'(mem_write), 1'b0);
    chk("t5_read_clr", 1'(mem_read), 1'b0);
    chk("t5_d_resp", 1'(d_pmem_resp), 1'b0);
    chk("t5_i_resp", 1'(i_pmem_resp), 1'b0);
    advance();
    man_resp = 1'b0; auto_mem = 1'b1;
    tick();

    // Request held into RECOVER yields exactly one transaction
    base = rd_txns;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_7000;
    tick();
    check_cycle();
    advance();
    run_until_resp(1'b0, n);
    advance();
    check_cycle();
    chk("t6_recover_idle", 1'(mem_read), 1'b0);
    i_pmem_read = 1'b0;
    advance();
    for (int k = 0; k < 5; k++) tick();
    chk("t6_one_txn", LW'(rd_txns - base), LW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
